// File: rtl/tipi_serial_pkg.sv
// Shared types and constants for the TI<->Pi serial registers.
// Holds the transmit FSM state type, default data width and counter-width helper.
package tipi_serial_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StShift = 1'b1
  } tx_state_e;

  // Bit counter must be able to hold WIDTH itself without wrapping.
  function automatic int unsigned bitcnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a registered rising-edge detector per bit.
// sync_o is delayed one extra flop so it lines up with rise_o for sampling.
module sync_edge_detect #(
  parameter int unsigned Stages = 2,
  parameter int unsigned Width  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] sync_o,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] chain_d [Stages+1];
  logic [Width-1:0] chain_q [Stages+1];
  logic [Width-1:0] rise_d;
  logic [Width-1:0] rise_q;

  always_comb begin
    chain_d[0] = d_i;
    for (int unsigned i = 1; i <= Stages; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    rise_d = chain_q[Stages-1] & ~chain_q[Stages];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i <= Stages; i++) begin
        chain_q[i] <= '0;
      end
      rise_q <= '0;
    end else begin
      for (int unsigned i = 0; i <= Stages; i++) begin
        chain_q[i] <= chain_d[i];
      end
      rise_q <= rise_d;
    end
  end

  assign sync_o = chain_q[Stages];
  assign rise_o = rise_q;

endmodule

// File: rtl/tipi_byte_serializer.sv
// TI->Pi parallel-in/serial-out transmit register, MSB (bit 0) shifted first.
// Define TIPI_TX_PARITY_EN to build the registered XOR-parity output.
module tipi_byte_serializer
  import tipi_serial_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [0:WIDTH-1] din,
  input  logic             clear,
  input  logic             sclk,
  input  logic             select,
  input  logic             le,
  output logic             full,
  output logic             busy,
  output logic             done,
  output logic             dout,
  output logic             parity,
  output logic             overrun,
  output logic             underrun
);

  localparam int unsigned     CntW    = bitcnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Synchronized Pi-side controls
  logic       sclk_rise;
  logic [1:0] ctrl_sync;
  logic       sel_s;
  logic       le_s;
  logic       shift_ev;
  logic       unused_sclk_sync;
  logic [1:0] unused_ctrl_rise;

  sync_edge_detect #(
    .Stages (SYNC_STAGES),
    .Width  (1)
  ) u_sclk_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (sclk),
    .sync_o (unused_sclk_sync),
    .rise_o (sclk_rise)
  );

  sync_edge_detect #(
    .Stages (SYNC_STAGES),
    .Width  (2)
  ) u_ctrl_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    ({select, le}),
    .sync_o (ctrl_sync),
    .rise_o (unused_ctrl_rise)
  );

  assign sel_s    = ctrl_sync[1];
  assign le_s     = ctrl_sync[0];
  assign shift_ev = sclk_rise & sel_s;

  // State
  tx_state_e        state_d, state_q;
  logic [0:WIDTH-1] shifter_d, shifter_q;
  logic [0:WIDTH-1] hold_d, hold_q;
  logic [CntW-1:0]  bitcnt_d, bitcnt_q;
  logic             full_d, full_q;
  logic             done_d, done_q;
  logic             overrun_d, overrun_q;
  logic             underrun_d, underrun_q;
  logic             xfer;
  logic             underrun_set;
  logic             overrun_set;

  // Shift FSM: an le event (re)starts a transfer from either state.
  always_comb begin
    state_d      = state_q;
    shifter_d    = shifter_q;
    bitcnt_d     = bitcnt_q;
    done_d       = 1'b0;
    xfer         = 1'b0;
    underrun_set = 1'b0;
    if (shift_ev) begin
      if (le_s) begin
        if (full_q) begin
          shifter_d = hold_q;
          bitcnt_d  = '0;
          state_d   = StShift;
          xfer      = 1'b1;
        end else begin
          shifter_d    = '0;
          state_d      = StEmpty;
          underrun_set = 1'b1;
        end
      end else begin
        shifter_d = {shifter_q[1:WIDTH-1], 1'b0};
        if (state_q == StShift) begin
          bitcnt_d = bitcnt_q + CntW'(1);
          if (bitcnt_q == LastBit) begin
            state_d = StEmpty;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  // Holding register and sticky flags; a set beats a simultaneous clear.
  always_comb begin
    hold_d      = hold_q;
    full_d      = full_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    overrun_set = 1'b0;
    if (xfer) begin
      full_d = 1'b0;
    end
    if (load) begin
      if (!full_q || xfer) begin
        hold_d = din;
        full_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end
    if (clear) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (underrun_set) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StEmpty;
      shifter_q  <= '0;
      hold_q     <= '0;
      bitcnt_q   <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shifter_q  <= shifter_d;
      hold_q     <= hold_d;
      bitcnt_q   <= bitcnt_d;
      full_q     <= full_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef TIPI_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^shifter_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign full     = full_q;
  assign busy     = (state_q == StShift);
  assign done     = done_q;
  assign dout     = shifter_q[0];
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_tipi_byte_serializer.sv
// Bench for tipi_byte_serializer: table-driven steps through a scoreboard queue,
// plus hand-written select-gating and asynchronous mid-transfer reset sequences.
module tb_tipi_byte_serializer;

  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 2;
`ifdef TIPI_TX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         load    = 1'b0;
  logic         clear   = 1'b0;
  logic         sclk    = 1'b0;
  logic         select  = 1'b0;
  logic         le      = 1'b0;
  logic [0:W-1] din     = '0;
  logic         full, busy, done, dout, parity, overrun, underrun;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  tipi_byte_serializer #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .din      (din),
    .clear    (clear),
    .sclk     (sclk),
    .select   (select),
    .le       (le),
    .full     (full),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .parity   (parity),
    .overrun  (overrun),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum {OpLoad, OpXfer, OpShift, OpClear, OpLoadXfer} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic [7:0] sh;
    logic       full;
    logic       busy;
    logic       ovr;
    logic       und;
    int         done;
  } step_t;

  step_t tbl[$];
  step_t sb[$];

  function automatic void add(input op_e op, input logic [7:0] data, input logic [7:0] sh,
                              input logic f, input logic b, input logic o, input logic u,
                              input int dn);
    step_t s;
    s.op = op; s.data = data; s.sh = sh; s.full = f; s.busy = b;
    s.ovr = o; s.und = u; s.done = dn;
    tbl.push_back(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_load(input logic [7:0] d);
    @(negedge clk); load = 1'b1; din = d;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    @(negedge clk);
  endtask

  // One sclk rise with the given select/le; optionally lands a load on the event clk.
  task automatic sclk_event(input logic sel, input logic le_v, input bit with_load,
                            input logic [7:0] d);
    @(negedge clk); select = sel; le = le_v;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    if (with_load) begin
      repeat (SYNC + 1) @(negedge clk);
      load = 1'b1; din = d;
      @(negedge clk); load = 1'b0;
      repeat (6 - SYNC - 2) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    select = 1'b0; le = 1'b0;
  endtask

  task automatic apply(input step_t s);
    case (s.op)
      OpLoad:     pulse_load(s.data);
      OpClear:    pulse_clear();
      OpXfer:     sclk_event(1'b1, 1'b1, 1'b0, 8'h00);
      OpShift:    sclk_event(1'b1, 1'b0, 1'b0, 8'h00);
      OpLoadXfer: sclk_event(1'b1, 1'b1, 1'b1, s.data);
      default:    ;
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".full"}, full, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".dout"}, dout, 0);
    check({tag, ".parity"}, parity, 0);
    check({tag, ".overrun"}, overrun, 0);
    check({tag, ".underrun"}, underrun, 0);
  endtask

  initial begin
    step_t exp;
    int    d0;

    //    op          data   shifter full busy ovr und done
    // 8'hA5 walk-through
    add(OpLoad,     8'hA5, 8'h00, 1, 0, 0, 0, 0);
    add(OpXfer,     8'h00, 8'hA5, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h4A, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h94, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h28, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h50, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'hA0, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h40, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h80, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h00, 0, 0, 0, 0, 1);
    // overrun keeps the first byte
    add(OpLoad,     8'h3C, 8'h00, 1, 0, 0, 0, 0);
    add(OpLoad,     8'hFF, 8'h00, 1, 0, 1, 0, 0);
    add(OpClear,    8'h00, 8'h00, 1, 0, 0, 0, 0);
    add(OpXfer,     8'h00, 8'h3C, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h78, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'hF0, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'hE0, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'hC0, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h80, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h00, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h00, 0, 1, 0, 0, 0);
    add(OpShift,    8'h00, 8'h00, 0, 0, 0, 0, 1);
    // underrun
    add(OpXfer,     8'h00, 8'h00, 0, 0, 0, 1, 0);
    add(OpClear,    8'h00, 8'h00, 0, 0, 0, 0, 0);
    // load in the transfer clk, then restarts
    add(OpLoad,     8'h81, 8'h00, 1, 0, 0, 0, 0);
    add(OpLoadXfer, 8'h7E, 8'h81, 1, 1, 0, 0, 0);
    add(OpXfer,     8'h00, 8'h7E, 0, 1, 0, 0, 0);
    add(OpXfer,     8'h00, 8'h00, 0, 0, 0, 1, 0);
    add(OpClear,    8'h00, 8'h00, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      d0 = done_cnt;
      sb.push_back(tbl[i]);
      apply(tbl[i]);
      exp = sb.pop_front();
      check($sformatf("step%0d.dout", i), dout, exp.sh[7]);
      check($sformatf("step%0d.parity", i), parity, ParEn ? ^exp.sh : 1'b0);
      check($sformatf("step%0d.full", i), full, exp.full);
      check($sformatf("step%0d.busy", i), busy, exp.busy);
      check($sformatf("step%0d.overrun", i), overrun, exp.ovr);
      check($sformatf("step%0d.underrun", i), underrun, exp.und);
      check($sformatf("step%0d.done", i), done_cnt - d0, exp.done);
    end

    // Select gating mid-transfer: 8'hF0 shifted 3 times leaves 8'h80, bitcnt 3
    pulse_load(8'hF0);
    sclk_event(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (3) sclk_event(1'b1, 1'b0, 1'b0, 8'h00);
    d0 = done_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); le = k[0]; sclk = 1'b1;
      repeat (3) @(negedge clk); sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    le = 1'b0;
    repeat (4) @(negedge clk);
    check("gate.dout", dout, 1);
    check("gate.parity", parity, ParEn ? 1'b1 : 1'b0);
    check("gate.busy", busy, 1);
    check("gate.flags", {full, overrun, underrun}, 3'b000);
    check("gate.done", done_cnt - d0, 0);
    repeat (4) sclk_event(1'b1, 1'b0, 1'b0, 8'h00);
    check("gate.busy_after7", busy, 1);
    check("gate.early_done", done_cnt - d0, 0);
    sclk_event(1'b1, 1'b0, 1'b0, 8'h00);
    check("gate.busy_after8", busy, 0);
    check("gate.done_after8", done_cnt - d0, 1);

    // Asynchronous reset after the 3rd shift of 8'hF0, with full and overrun set
    pulse_load(8'hF0);
    sclk_event(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (3) sclk_event(1'b1, 1'b0, 1'b0, 8'h00);
    pulse_load(8'h55);
    pulse_load(8'h66);
    check("prerst.dout", dout, 1);
    check("prerst.busy", busy, 1);
    check("prerst.full", full, 1);
    check("prerst.overrun", overrun, 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    sclk_event(1'b1, 1'b1, 1'b0, 8'h00);
    check("postrst.underrun", underrun, 1);
    check("postrst.busy", busy, 0);
    check("postrst.dout", dout, 0);
    check("postrst.full", full, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
